multdiv_sequencer: RTL and testbench

Multi-cycle multiply/divide controller for the 5-stage pipelined processor. It accepts `mul`/`div` operations from the execute stage and runs a 32-iteration signed shift-add multiply or restoring divide. While it runs it holds the F/D, D/X and PC latches with a stall signal, then returns a one-cycle result pulse that lets the instruction advance into X/M carrying its product or quotient and exception flag. Exceptions are consumed downstream for the `$rstatus` write.

---
 rtl/multdiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide on operand magnitudes, stalling the front of the pipe while it runs.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic [4:0]       rd_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction

  logic [1:0]         state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opd_r;
  logic               sign_r;
  logic [4:0]         rd_r;
  logic               busy_r, rdy_r, exc_r;
  logic [WIDTH-1:0]   result_r;
  logic [4:0]         rd_out_r;

  logic               last_s, div_zero_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;
  logic [WIDTH-1:0]   quo_mag_s, quo_s, fin_result_s;
  logic               mul_ovf_s, div_ovf_s, fin_exc_s;

  assign last_s     = (cnt_r == {CNT_W{1'b1}});
  assign div_zero_s = (data_operandB == {WIDTH{1'b0}});

  // Multiply step: accumulator upper half holds partial product, lower half the multiplier.
  assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opd_r};
  assign mul_next_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]}
                               : {1'b0, acc_r[2*WIDTH-1:1]};

  // Divide step: accumulator is {remainder, quotient}; remainder stays below the divisor.
  assign div_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_diff_s = div_sh_s - {1'b0, opd_r};
  assign div_next_s = div_diff_s[WIDTH] ? {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                        : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

  // Signed product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
  assign prod_s    = sign_r ? (~mul_next_s + ONE_2W) : mul_next_s;
  assign mul_ovf_s = (|prod_s[2*WIDTH-1:WIDTH-1]) & ~(&prod_s[2*WIDTH-1:WIDTH-1]);
  assign quo_mag_s = div_next_s[WIDTH-1:0];
  assign quo_s     = sign_r ? (~quo_mag_s + ONE_W) : quo_mag_s;
  assign div_ovf_s = ~sign_r & quo_mag_s[WIDTH-1];

  assign stall = ((state_r == ST_IDLE) & (ctrl_MULT | ctrl_DIV)) |
                 (state_r == ST_MUL) | (state_r == ST_DIV);

  assign busy           = busy_r;
  assign data_resultRDY = rdy_r;
  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign rd_out         = rd_out_r;

  // Next-state decode; a start is only honoured in IDLE and multiply has priority.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          state_nxt_s = ST_MUL;
        end else if (ctrl_DIV) begin
          state_nxt_s = div_zero_s ? ST_DONE : ST_DIV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: state_nxt_s = last_s ? ST_DONE : state_r;
      ST_DONE:        state_nxt_s = ST_IDLE;
      default:        state_nxt_s = ST_IDLE;
    endcase
  end

  // Result and exception presented on entry to DONE.
  always_comb begin
    fin_result_s = {WIDTH{1'b0}};
    fin_exc_s    = 1'b0;
    case (state_r)
      ST_MUL: begin
        fin_result_s = prod_s[WIDTH-1:0];
        fin_exc_s    = mul_ovf_s;
      end
      ST_DIV: begin
        fin_result_s = quo_s;
        fin_exc_s    = div_ovf_s;
      end
      ST_IDLE: begin
        fin_result_s = {WIDTH{1'b0}};
        fin_exc_s    = 1'b1;
      end
      default: begin
        fin_result_s = {WIDTH{1'b0}};
        fin_exc_s    = 1'b0;
      end
    endcase
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      opd_r    <= {WIDTH{1'b0}};
      sign_r   <= 1'b0;
      rd_r     <= 5'd0;
      busy_r   <= 1'b0;
      rdy_r    <= 1'b0;
      exc_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      rd_out_r <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_MUL) | (state_nxt_s == ST_DIV);
      rdy_r   <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (ctrl_MULT | ctrl_DIV) begin
            cnt_r  <= {CNT_W{1'b0}};
            sign_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rd_r   <= rd_in;
            if (ctrl_MULT) begin
              acc_r <= {{WIDTH{1'b0}}, magnitude(data_operandB)};
              opd_r <= magnitude(data_operandA);
            end else begin
              acc_r <= {{WIDTH{1'b0}}, magnitude(data_operandA)};
              opd_r <= magnitude(data_operandB);
            end
          end
        end
        ST_MUL: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r + ONE_C;
        end
        ST_DIV: begin
          acc_r <= div_next_s;
          cnt_r <= cnt_r + ONE_C;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
      if (state_nxt_s == ST_DONE && state_r != ST_DONE) begin
        result_r <= fin_result_s;
        exc_r    <= fin_exc_s;
        rd_out_r <= (state_r == ST_IDLE) ? rd_in : rd_r;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Table-driven bench for multdiv_sequencer with a result scoreboard keyed on the
// cycle each RDY pulse is due.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        stall, busy, data_resultRDY, data_exception;
  logic [31:0] data_result;
  logic [4:0]  rd_out;

  multdiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .rd_in(rd_in),
    .stall(stall), .busy(busy), .data_resultRDY(data_resultRDY),
    .data_result(data_result), .data_exception(data_exception), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mul;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        exc;
    int          lat;
    logic        hold;
    int          inj;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard side: every RDY pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      exp_t e;
      rdy_cnt++;
      if (sb.size() == 0) begin
        check("spurious_rdy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("rdy_cycle", cyc, e.due);
      end
    end
  end

  // Issue one operation at the current cycle (C0) and follow it to the first IDLE cycle.
  task automatic run_vec(input vec_t v);
    int   c0;
    int   stall_cnt;
    exp_t e;
    c0 = cyc;
    ctrl_MULT = v.mul;
    ctrl_DIV = v.div;
    data_operandA = v.a;
    data_operandB = v.b;
    rd_in = v.rd;
    e.res = v.res; e.exc = v.exc; e.rd = v.rd; e.due = c0 + v.lat;
    sb.push_back(e);
    stall_cnt = 0;
    for (int k = 0; k <= v.lat + 1; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      if (k <= v.lat && stall === 1'b1) stall_cnt++;
      if (k == 1 && !v.hold) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
      end
      if (v.inj != 0 && k == v.inj) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
      end
      if (v.inj != 0 && k == v.inj + 1) ctrl_DIV = 1'b0;
    end
    check("stall_cycles", stall_cnt, v.lat);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("result_hold", data_result, v.res);
    check("rdy_seen", sb.size(), 32'd0);
    sb.delete();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  initial begin
    int rdy_before;
    vec_t v6x7;
    //        mul   div   a             b             rd     res           exc   lat hold  inj
    vecs[0]  = '{1'b1, 1'b0, 32'h00000003, 32'hFFFFFFFB, 5'd4,  32'hFFFFFFF1, 1'b0, 33, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 5'd1,  32'h00000000, 1'b1, 33, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 5'd2,  32'h80000000, 1'b0, 33, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 5'd3,  32'h80000000, 1'b1, 33, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFE, 1'b1, 33, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'd100,      32'd7,        5'd6,  32'h0000000E, 1'b0, 33, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFF2, 1'b0, 33, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'd7,        32'd100,      5'd8,  32'h00000000, 1'b0, 33, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 1'b1, 33, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 32'd5,        32'd0,        5'd10, 32'h00000000, 1'b1, 1,  1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h00012345, 32'h00000100, 5'd11, 32'h01234500, 1'b0, 33, 1'b0, 10};
    vecs[11] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFF7, 5'd12, 32'h0000003F, 1'b0, 33, 1'b1, 0};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFFFC18, 32'hFFFFFFF6, 5'd13, 32'h00000064, 1'b0, 33, 1'b0, 0};
    vecs[13] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        5'd14, 32'hC0000000, 1'b0, 33, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 32'd0,        32'hFFFFFFFB, 5'd15, 32'h00000000, 1'b0, 33, 1'b0, 0};
    v6x7     = '{1'b1, 1'b0, 32'd6,        32'd7,        5'd16, 32'd42,       1'b0, 33, 1'b0, 0};

    repeat (3) @(negedge clock);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1;

    // Vectors run back to back: each starts in the first IDLE cycle after the previous DONE.
    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset in C15 of a divide: outputs drop at once and no RDY follows.
    rdy_before = rdy_cnt;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    rd_in = 5'd20;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k == 1) ctrl_DIV = 1'b0;
    end
    #1;
    check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("no_rdy_after_reset", rdy_cnt, rdy_before);
    #1;
    run_vec(v6x7);
    check("rdy_total", rdy_cnt, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
